// File: rtl/spdif_stream_scheduler_pkg.sv
// Shared types and constants for the S/PDIF stream scheduler.
// Optional feature macro used by the scheduler: SPDIF_SCHED_HOLD_LAST_EN.
package spdif_pkg;

   localparam int SAMPLE_W    = 24;
   localparam int SLOT_CYCLES = 256;
   localparam int SLOT_CNT_W  = $clog2(SLOT_CYCLES);

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SEND_L = 2'd1,
      SEND_R = 2'd2
   } state_e;

   localparam logic [SAMPLE_W-1:0] MUTE_SAMPLE = '0;

endpackage

// File: rtl/spdif_stream_scheduler_slot_timer.sv
// Free-running frame slot timer: one tick per SLOT_CYCLES, a sticky pending flag
// and a saturating count of ticks that arrived while the previous slot was unfinished.
module spdif_slot_timer
   import spdif_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk256,
   input  logic             reset,
   input  logic             busy_i,
   input  logic             clear_i,
   output logic             slot_pending_o,
   output logic [CNT_W-1:0] late_count_o
);

   logic [SLOT_CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic                  slot_pending_q, slot_pending_d;
   logic [CNT_W-1:0]      late_q, late_d;
   logic                  tick;

   assign tick = (slot_cnt_q == SLOT_CNT_W'(SLOT_CYCLES - 1));

   always_comb begin
      slot_cnt_d     = slot_cnt_q + 1'b1;
      slot_pending_d = slot_pending_q;
      late_d         = late_q;
      // A tick always wins over a simultaneous clear so no slot is ever lost.
      if (tick) begin
         slot_pending_d = 1'b1;
      end else if (clear_i) begin
         slot_pending_d = 1'b0;
      end
      if (tick && (busy_i || slot_pending_q) && (late_q != '1)) begin
         late_d = late_q + 1'b1;
      end
   end

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset) begin
         slot_cnt_q     <= '0;
         slot_pending_q <= 1'b0;
         late_q         <= '0;
      end else begin
         slot_cnt_q     <= slot_cnt_d;
         slot_pending_q <= slot_pending_d;
         late_q         <= late_d;
      end
   end

   assign slot_pending_o = slot_pending_q;
   assign late_count_o   = late_q;

endmodule

// File: rtl/spdif_stream_scheduler.sv
// Picks one stereo pair per frame slot from the selected source and feeds it, L then R,
// to the S/PDIF transmitter. Define SPDIF_SCHED_HOLD_LAST_EN to repeat the last pair on underrun.
module spdif_stream_scheduler
   import spdif_pkg::*;
#(
   parameter int NUM_SOURCES = 2,
   parameter int SEL_W       = 3,
   parameter int CNT_W       = 16
) (
   input  logic                            reset,
   input  logic                            clk256,
   input  logic [SEL_W-1:0]                i_sel,
   input  logic [NUM_SOURCES-1:0]          src_valid,
   output logic [NUM_SOURCES-1:0]          src_ready,
   input  logic [NUM_SOURCES*SAMPLE_W-1:0] src_left,
   input  logic [NUM_SOURCES*SAMPLE_W-1:0] src_right,
   output logic                            o_valid,
   input  logic                            o_ready,
   output logic                            o_is_left,
   output logic [SAMPLE_W-1:0]             o_audio,
   output logic [CNT_W-1:0]                o_underrun_count,
   output logic [CNT_W-1:0]                o_late_count
);

   state_e                state_q, state_d;
   logic [SAMPLE_W-1:0]   pair_l_q, pair_l_d, pair_r_q, pair_r_d;
   logic                  o_valid_q, o_valid_d;
   logic                  o_is_left_q, o_is_left_d;
   logic [SAMPLE_W-1:0]   o_audio_q, o_audio_d;
   logic [CNT_W-1:0]      underrun_q, underrun_d;

   logic                  slot_pending;
   logic                  decide, take, sel_in_range, sel_valid;
   logic [SAMPLE_W-1:0]   sel_l, sel_r, mute_l, mute_r;

   spdif_slot_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk256        (clk256),
      .reset         (reset),
      .busy_i        (state_q != WAIT),
      .clear_i       (decide),
      .slot_pending_o(slot_pending),
      .late_count_o  (o_late_count)
   );

   assign sel_in_range = (int'(i_sel) < NUM_SOURCES);
   assign decide       = (state_q == WAIT) && slot_pending;
   assign take         = decide && sel_in_range && sel_valid;

   always_comb begin
      sel_valid = 1'b0;
      sel_l     = '0;
      sel_r     = '0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
         if (i_sel == SEL_W'(k)) begin
            sel_valid = src_valid[k];
            sel_l     = src_left[k*SAMPLE_W +: SAMPLE_W];
            sel_r     = src_right[k*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ready
      assign src_ready[gi] = take && (i_sel == SEL_W'(gi));
   end

`ifdef SPDIF_SCHED_HOLD_LAST_EN
   logic [SAMPLE_W-1:0] last_l_q, last_r_q;

   // An out-of-range select is a deliberate mute, so it never repeats old audio.
   assign mute_l = sel_in_range ? last_l_q : MUTE_SAMPLE;
   assign mute_r = sel_in_range ? last_r_q : MUTE_SAMPLE;

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset) begin
         last_l_q <= '0;
         last_r_q <= '0;
      end else if (take) begin
         last_l_q <= sel_l;
         last_r_q <= sel_r;
      end
   end
`else
   assign mute_l = MUTE_SAMPLE;
   assign mute_r = MUTE_SAMPLE;
`endif

   always_comb begin
      state_d    = state_q;
      pair_l_d   = pair_l_q;
      pair_r_d   = pair_r_q;
      underrun_d = underrun_q;
      case (state_q)
         WAIT: begin
            if (slot_pending) begin
               if (take) begin
                  pair_l_d = sel_l;
                  pair_r_d = sel_r;
               end else begin
                  pair_l_d = mute_l;
                  pair_r_d = mute_r;
                  if (underrun_q != '1) underrun_d = underrun_q + 1'b1;
               end
               state_d = SEND_L;
            end
         end
         SEND_L:  if (o_ready) state_d = SEND_R;
         SEND_R:  if (o_ready) state_d = WAIT;
         default: state_d = WAIT;
      endcase

      // Outputs are registered from the next state, giving one cycle decision-to-valid.
      o_valid_d   = 1'b0;
      o_is_left_d = 1'b1;
      o_audio_d   = '0;
      case (state_d)
         SEND_L: begin
            o_valid_d   = 1'b1;
            o_is_left_d = 1'b1;
            o_audio_d   = pair_l_d;
         end
         SEND_R: begin
            o_valid_d   = 1'b1;
            o_is_left_d = 1'b0;
            o_audio_d   = pair_r_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT;
         pair_l_q    <= '0;
         pair_r_q    <= '0;
         o_valid_q   <= 1'b0;
         o_is_left_q <= 1'b1;
         o_audio_q   <= '0;
         underrun_q  <= '0;
      end else begin
         state_q     <= state_d;
         pair_l_q    <= pair_l_d;
         pair_r_q    <= pair_r_d;
         o_valid_q   <= o_valid_d;
         o_is_left_q <= o_is_left_d;
         o_audio_q   <= o_audio_d;
         underrun_q  <= underrun_d;
      end
   end

   assign o_valid          = o_valid_q;
   assign o_is_left        = o_is_left_q;
   assign o_audio          = o_audio_q;
   assign o_underrun_count = underrun_q;

endmodule

// File: tb/tb_spdif_stream_scheduler.sv
// Scoreboard bench for spdif_stream_scheduler: stimulus pushes expected L/R transfers,
// a negedge monitor pops and compares on every transmitter handshake.
module tb_spdif_stream_scheduler;

   localparam int NS = 2;

   logic          reset, clk256;
   logic [2:0]    i_sel;
   logic [NS-1:0] src_valid, src_ready;
   logic [47:0]   src_left, src_right;
   logic          o_valid, o_ready, o_is_left;
   logic [23:0]   o_audio;
   logic [15:0]   o_underrun_count, o_late_count;

   spdif_stream_scheduler #(.NUM_SOURCES(NS), .SEL_W(3), .CNT_W(16)) dut (
      .reset(reset), .clk256(clk256), .i_sel(i_sel),
      .src_valid(src_valid), .src_ready(src_ready),
      .src_left(src_left), .src_right(src_right),
      .o_valid(o_valid), .o_ready(o_ready), .o_is_left(o_is_left), .o_audio(o_audio),
      .o_underrun_count(o_underrun_count), .o_late_count(o_late_count)
   );

   initial clk256 = 1'b0;
   always #5 clk256 = ~clk256;

   typedef struct packed {
      logic        is_left;
      logic [23:0] audio;
   } exp_t;

   exp_t sb[$];
   int   hs_cyc[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   pulses0 = 0;
   int   pulses1 = 0;
   exp_t mon_e;

   always @(posedge clk256) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
      sb.push_back({1'b1, l});
      sb.push_back({1'b0, r});
   endtask

   // Monitor: one line per transmitter transfer.
   always @(negedge clk256) begin
      if (!reset && o_valid && o_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transfer: got is_left=%0b audio=%06h expected none", o_is_left, o_audio);
         end else begin
            mon_e = sb.pop_front();
            $display("xfer cycle=%0d is_left=%0b audio=%06h exp=%06h", cyc, o_is_left, o_audio, mon_e.audio);
            check("xfer_is_left", 32'(o_is_left), 32'(mon_e.is_left));
            check("xfer_audio", 32'(o_audio), 32'(mon_e.audio));
         end
         hs_cyc.push_back(cyc);
      end
      if (src_ready != '0) begin
         if (src_ready[0]) pulses0++;
         if (src_ready[1]) pulses1++;
         check("src_ready_onehot", 32'($onehot(src_ready)), 32'd1);
      end
   end

   task automatic wait_empty(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk256);
         #1;
      end
      check("queue_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_valid(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(posedge clk256);
         #1;
         if (o_valid) break;
      end
      check("o_valid_seen", 32'(o_valid), 32'd1);
   endtask

   task automatic check_reset_values();
      check("rst_src_ready", 32'(src_ready), 32'd0);
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_is_left", 32'(o_is_left), 32'd1);
      check("rst_o_audio", 32'(o_audio), 32'd0);
      check("rst_underrun", 32'(o_underrun_count), 32'd0);
      check("rst_late", 32'(o_late_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, p1, bad, n;
      reset     = 1'b1;
      o_ready   = 1'b0;
      i_sel     = 3'd0;
      src_valid = '0;
      src_left  = {24'h654321, 24'h123456};
      src_right = {24'hFEDCBA, 24'hABCDEF};
      repeat (3) @(posedge clk256);
      #1;
      check_reset_values();

      // Source 0 always valid, transmitter always ready.
      src_valid = 2'b01;
      o_ready   = 1'b1;
      reset     = 1'b0;
      hs_cyc.delete();
      repeat (3) push_pair(24'h123456, 24'hABCDEF);
      wait_empty(1200);
      check("s1_pulses0", 32'(pulses0), 32'd3);
      check("s1_handshakes", 32'(hs_cyc.size()), 32'd6);
      if (hs_cyc.size() == 6) begin
         check("s1_slot_spacing_a", 32'(hs_cyc[2] - hs_cyc[0]), 32'd256);
         check("s1_slot_spacing_b", 32'(hs_cyc[4] - hs_cyc[2]), 32'd256);
      end
      check("s1_underrun", 32'(o_underrun_count), 32'd0);
      check("s1_late", 32'(o_late_count), 32'd0);

      // Selected source never valid: three underrun slots.
      src_valid = 2'b00;
      i_sel     = 3'd1;
      p0 = pulses0; p1 = pulses1;
`ifdef SPDIF_SCHED_HOLD_LAST_EN
      repeat (3) push_pair(24'h123456, 24'hABCDEF);
`else
      repeat (3) push_pair(24'h000000, 24'h000000);
`endif
      wait_empty(1200);
      check("s2_underrun", 32'(o_underrun_count), 32'd3);
      check("s2_no_ready", 32'(pulses0 + pulses1 - p0 - p1), 32'd0);

      // Select changes between L and R handshakes.
      src_valid = 2'b11;
      i_sel     = 3'd0;
      o_ready   = 1'b0;
      p0 = pulses0; p1 = pulses1;
      push_pair(24'h123456, 24'hABCDEF);
      push_pair(24'h654321, 24'hFEDCBA);
      wait_valid(600);
      o_ready = 1'b1;
      @(posedge clk256);
      #1;
      i_sel = 3'd1;
      wait_empty(600);
      check("s3_pulses0", 32'(pulses0 - p0), 32'd1);
      check("s3_pulses1", 32'(pulses1 - p1), 32'd1);
      check("s3_late", 32'(o_late_count), 32'd0);

      // Transmitter stalls 300 cycles in SEND_L: one late tick, immediate next pair.
      o_ready = 1'b0;
      push_pair(24'h654321, 24'hFEDCBA);
      push_pair(24'h654321, 24'hFEDCBA);
      wait_valid(600);
      bad = 0;
      repeat (300) begin
         @(negedge clk256);
         if (!(o_valid === 1'b1 && o_is_left === 1'b1 && o_audio === 24'h654321)) bad++;
      end
      check("s4_stall_stable", 32'(bad), 32'd0);
      check("s4_late_count", 32'(o_late_count), 32'd1);
      hs_cyc.delete();
      @(posedge clk256);
      #1;
      o_ready = 1'b1;
      wait_empty(600);
      check("s4_handshakes", 32'(hs_cyc.size()), 32'd4);
      if (hs_cyc.size() == 4) check("s4_restart_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
      check("s4_late_final", 32'(o_late_count), 32'd1);

      // Out-of-range select always mutes, even with both sources valid.
      i_sel = 3'd7;
      p0 = pulses0; p1 = pulses1;
      repeat (2) push_pair(24'h000000, 24'h000000);
      wait_empty(1200);
      check("s5_underrun", 32'(o_underrun_count), 32'd5);
      check("s5_no_ready", 32'(pulses0 + pulses1 - p0 - p1), 32'd0);

      // Reset while in SEND_R abandons the pair.
      i_sel     = 3'd0;
      src_valid = 2'b01;
      o_ready   = 1'b0;
      sb.push_back({1'b1, 24'h123456});
      wait_valid(600);
      o_ready = 1'b1;
      @(posedge clk256);
      #1;
      o_ready = 1'b0;
      check("s6_in_send_r", 32'(o_is_left), 32'd0);
      reset = 1'b1;
      #1;
      check_reset_values();
      repeat (3) @(posedge clk256);
      #1;
      reset   = 1'b0;
      o_ready = 1'b1;
      push_pair(24'h123456, 24'hABCDEF);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk256);
         n++;
         #1;
         if (o_valid) break;
      end
      // Slot tick on the 256th edge after release, valid one edge later.
      check("s6_first_valid_edge", 32'(n), 32'd257);
      wait_empty(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spdif_stream_scheduler.md
Name: spdif_stream_scheduler

Overview:
- Sequences stereo sample pairs from NUM_SOURCES upstream producers into the single S/PDIF transmitter sample port (valid/ready, is_left, 24-bit audio).
- Runs in the clk256 domain (256·fs) and opens one frame slot every 256 cycles.
- Each slot emits exactly one pair, strictly L then R, from the currently selected source; if that source has no pair ready, a mute pair is emitted instead.
- Source switching happens only at frame boundaries, so the L/R pairing is never broken.

Parameters:
- NUM_SOURCES, 2, number of stereo producers (1..8).
- SEL_W, 3, width of i_sel.
- CNT_W, 16, width of the saturating underrun and late counters.

Ports:
- reset  in  1  asynchronous, active-high
- clk256  in  1  256·fs clock
- i_sel  in  SEL_W  source select; value ≥ NUM_SOURCES selects mute
- src_valid  in  NUM_SOURCES  per-source pair available
- src_ready  out  NUM_SOURCES  per-source pair accepted; one-hot or zero
- src_left  in  NUM_SOURCES*24  left samples, source k at bits [24k+23:24k]
- src_right  in  NUM_SOURCES*24  right samples, same packing
- o_valid  out  1  to transmitter i_valid
- o_ready  in  1  from transmitter i_ready
- o_is_left  out  1  to transmitter i_is_left
- o_audio  out  24  to transmitter i_audio
- o_underrun_count  out  CNT_W  number of slots filled with mute because the source was not ready
- o_late_count  out  CNT_W  number of slot ticks that occurred while a pair was still in flight

Behaviour:
- Reset values: src_ready=0, o_valid=0, o_is_left=1, o_audio=0, both counters=0, slot_cnt=0, slot_pending=0, state=WAIT.
- Slot timer:
  - 8-bit slot_cnt free-runs; tick when slot_cnt==255.
  - A tick sets the sticky slot_pending.
  - A tick while state≠WAIT, or while slot_pending is already 1, increments o_late_count (saturating). Ticks are never queued deeper than one.
- State WAIT, when slot_pending=1:
  - Latch sel=i_sel.
  - If sel<NUM_SOURCES and src_valid[sel]=1: drive src_ready[sel]=1 for exactly this cycle, capture L/R into the pair register, go to SEND_L.
  - Otherwise: load the pair register with the mute pair, increment o_underrun_count (saturating), go to SEND_L. src_ready stays 0.
  - Clear slot_pending on this transition. If a tick coincides with this cycle, the tick wins and slot_pending stays 1 (counted late only if it was already set).
- State SEND_L:
  - o_valid=1, o_is_left=1, o_audio=L.
  - When o_ready=1, go to SEND_R.
- State SEND_R:
  - o_valid=1, o_is_left=0, o_audio=R.
  - When o_ready=1, go to WAIT.
- Handshake rules:
  - o_valid, o_is_left and o_audio are registered and stable while o_valid=1 and o_ready=0.
  - o_valid never drops without a handshake.
  - Latency from slot decision to o_valid=1 is 1 cycle.
  - Back-to-back L and R transfers are allowed, one per cycle.
- i_sel:
  - Sampled only in WAIT at the slot decision; changes mid-pair have no effect.
  - An out-of-range value gives a continuous mute stream, each mute slot counted as underrun.
- Reset asserted mid-pair: the pair is abandoned and all state returns to reset values. The transmitter side is reset by the same signal.
- src_ready is never asserted outside a slot decision, so at most one pair is consumed per slot. A source valid without a slot is left waiting.

Optional Feature:
- Macro: SPDIF_SCHED_HOLD_LAST_EN.
- Defined: the mute pair is the last pair actually taken from a source (reset value 0/0). Underrun repeats that sample, but an out-of-range sel still emits 0/0.
- Undefined: the mute pair is always 0/0, and no last-pair registers are built.
- Underrun counting is identical in both cases.

Decomposition:
- Shared package spdif_pkg:
  - SAMPLE_W=24
  - SLOT_CYCLES=256
  - state enum {WAIT, SEND_L, SEND_R}
  - MUTE_SAMPLE constant
- Sub-module spdif_slot_timer: slot_cnt, tick, sticky slot_pending with clear input, and the late counter.
- Source mux and FSM stay in the top module.

Test Plan:
- Source 0 always valid with L=0x123456, R=0xABCDEF, o_ready=1, sel=0 → every 256 cycles one L then R transfer with exact values; src_ready[0] pulses once per slot; counters stay 0.
- src_valid=0, sel=1 for 3 slots → 3 pairs of 0/0 emitted, o_underrun_count=3, src_ready stays 0. With SPDIF_SCHED_HOLD_LAST_EN, the last taken pair is repeated instead.
- i_sel toggled 0→1 between the L and R handshakes → R still comes from source 0; the next slot takes from source 1.
- o_ready held 0 for 300 cycles during SEND_L → o_valid and o_audio are stable throughout; o_late_count=1; the next pair starts immediately after R completes.
- i_sel=7 with NUM_SOURCES=2 → mute pairs emitted, underrun counted each slot, no src_ready asserted.
- reset pulsed while in SEND_R → all outputs return to reset values; the first slot after reset occurs 256 cycles after release.
